// File: rtl/deco_pkg.sv
// deco_pkg: shared constants and the code-to-one-hot mapping for deco_pipe.
//   CODE_W : code width (3)
//   LINE_W : one-hot width, 2**CODE_W (8)
//   CNT_W  : width of the delivered-beat statistics counter (DECO_STATS_EN builds)
//   code_to_onehot(code, en) : MSB-first one-hot word, or all zeros when en=0
package deco_pkg;

    localparam int CODE_W = 3;
    localparam int LINE_W = 2 ** CODE_W;
    localparam int CNT_W  = 16;

    // MSB-first: code 0 lights the top line, code LINE_W-1 lights bit 0.
    function automatic logic [LINE_W-1:0] code_to_onehot(input logic [CODE_W-1:0] code,
                                                         input logic              en);
        logic [LINE_W-1:0] w_msb;
        w_msb = {1'b1, {(LINE_W-1){1'b0}}};
        return en ? (w_msb >> code) : '0;
    endfunction

endpackage

// File: rtl/deco_pipe_if.sv
// deco_pipe_if: input and output valid/ready streams of deco_pipe.
//   in_valid/in_code/in_en/in_ready : producer side (code beat in)
//   out_valid/out_onehot/out_ready  : consumer side (one-hot beat out)
// Modports: master = the environment driving beats in and taking them out,
//           slave  = the decoder block itself.
interface deco_pipe_if;
    import deco_pkg::*;

    logic              in_valid;
    logic [CODE_W-1:0] in_code;
    logic              in_en;
    logic              in_ready;
    logic              out_valid;
    logic [LINE_W-1:0] out_onehot;
    logic              out_ready;

    modport master (
        output in_valid, in_code, in_en, out_ready,
        input  in_ready, out_valid, out_onehot
    );

    modport slave (
        input  in_valid, in_code, in_en, out_ready,
        output in_ready, out_valid, out_onehot
    );
endinterface

// File: rtl/deco_fifo2.sv
// deco_fifo2: generic 2-entry valid/ready buffer.
//   clk, rst      : clock, synchronous active-high reset
//   i_valid/i_data/o_ready : write side; o_ready depends only on registered state
//   o_valid/o_data/i_ready : read side; o_data is the oldest entry
// Empty entries are kept at zero, so o_data reads 0 whenever o_valid is low.
module deco_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready
);
    logic [1:0]   r_count;
    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic         w_push;
    logic         w_pop;

    assign o_ready = !rst && (r_count != 2'd2);
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_head;
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= i_data;
                    else                 r_tail <= i_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    // Tail is zero unless full, so this also clears head on the last pop.
                    r_head  <= r_tail;
                    r_tail  <= '0;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Push+pop only happens at count 1 (push is blocked when full),
                    // so the new beat becomes the head directly.
                    r_head <= i_data;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/deco_pipe.sv
// deco_pipe: registered 3-to-8 MSB-first line decoder with a 2-entry
// valid/ready buffer between producer and consumer.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : deco_pipe_if.slave (in_valid/in_code/in_en/in_ready,
//               out_valid/out_onehot/out_ready)
//   dec_count : enabled (nonzero) beats delivered, saturating; only when the
//               DECO_STATS_EN macro is defined
module deco_pipe
    import deco_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    deco_pipe_if.slave      bus
`ifdef DECO_STATS_EN
    ,
    output logic [CNT_W-1:0] dec_count
`endif
);
    logic [LINE_W-1:0] w_wdata;

    // Decode at push time so the buffer stores ready-to-use words.
    assign w_wdata = code_to_onehot(bus.in_code, bus.in_en);

    deco_fifo2 #(.W(LINE_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_valid (bus.in_valid),
        .i_data  (w_wdata),
        .o_ready (bus.in_ready),
        .o_valid (bus.out_valid),
        .o_data  (bus.out_onehot),
        .i_ready (bus.out_ready)
    );

`ifdef DECO_STATS_EN
    logic             w_pop;
    logic [CNT_W-1:0] r_dec_count;

    assign w_pop     = bus.out_valid && bus.out_ready;
    assign dec_count = r_dec_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec_count <= '0;
        end else if (w_pop && (|bus.out_onehot) && (r_dec_count != {CNT_W{1'b1}})) begin
            r_dec_count <= r_dec_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_deco_pipe.sv
// tb_deco_pipe: directed self-checking bench for deco_pipe.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_deco_pipe;
    import deco_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    deco_pipe_if bus();

`ifdef DECO_STATS_EN
    logic [CNT_W-1:0] dec_count;
`endif

    deco_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef DECO_STATS_EN
        ,
        .dec_count (dec_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.in_code = 3'd0; bus.in_en = 1'b1; bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_onehot !== 8'h00) begin
                n_errors++;
                $display("FAIL reset_hold cyc=%0d in_ready=%b out_valid=%b onehot=%h required 0/0/00",
                         i, bus.in_ready, bus.out_valid, bus.out_onehot);
            end
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
        end
`ifdef DECO_STATS_EN
        n_checks++;
        if (dec_count !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_count dec_count=%0d required 0", dec_count);
        end
`endif
        $display("reset: done");
    endtask

    task automatic test_sweep();
        logic [7:0] exp_tab [8];
        exp_tab = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_en = 1'b1; bus.in_code = 3'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_onehot !== exp_tab[i] || bus.in_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL sweep code=%0d valid=%b onehot=%h in_ready=%b required 1/%h/1",
                         i, bus.out_valid, bus.out_onehot, bus.in_ready, exp_tab[i]);
            end else begin
                $display("sweep: code=%0d onehot=%h", i, bus.out_onehot);
            end
            if (i < 7) bus.in_code = 3'(i + 1);
            else       bus.in_valid = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_onehot !== 8'h00) begin
            n_errors++;
            $display("FAIL sweep_drain valid=%b onehot=%h required 0/00", bus.out_valid, bus.out_onehot);
        end
`ifdef DECO_STATS_EN
        n_checks++;
        if (dec_count !== 16'd8) begin
            n_errors++;
            $display("FAIL sweep_count dec_count=%0d required 8", dec_count);
        end
`endif
    endtask

    task automatic test_disable();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_en = 1'b0; bus.in_code = 3'b101;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_en = 1'b1;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_onehot !== 8'h00) begin
            n_errors++;
            $display("FAIL disable_beat valid=%b onehot=%h required 1/00", bus.out_valid, bus.out_onehot);
        end else begin
            $display("disable: code=5 en=0 onehot=%h", bus.out_onehot);
        end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL disable_drain valid=%b required 0", bus.out_valid);
        end
`ifdef DECO_STATS_EN
        n_checks++;
        if (dec_count !== 16'd8) begin
            n_errors++;
            $display("FAIL disable_count dec_count=%0d required 8", dec_count);
        end
`endif
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_en = 1'b1; bus.in_code = 3'd2;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_onehot !== 8'h20 || bus.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_first valid=%b onehot=%h in_ready=%b required 1/20/1",
                     bus.out_valid, bus.out_onehot, bus.in_ready);
        end
        bus.in_code = 3'd6;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_onehot !== 8'h20) begin
            n_errors++;
            $display("FAIL bp_full in_ready=%b onehot=%h required 0/20", bus.in_ready, bus.out_onehot);
        end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_onehot !== 8'h20 || bus.in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_hold valid=%b onehot=%h in_ready=%b required 1/20/0",
                     bus.out_valid, bus.out_onehot, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_onehot !== 8'h02 || bus.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_second valid=%b onehot=%h in_ready=%b required 1/02/1",
                     bus.out_valid, bus.out_onehot, bus.in_ready);
        end else begin
            $display("backpressure: beats 20 then %h", bus.out_onehot);
        end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_drain valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_simultaneous();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_en = 1'b1; bus.in_code = 3'd4;
        @(negedge clk);
        n_checks++;
        if (bus.out_onehot !== 8'h08 || bus.out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL simul_setup valid=%b onehot=%h required 1/08", bus.out_valid, bus.out_onehot);
        end
        bus.in_code = 3'd7; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_onehot !== 8'h01 || bus.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL simul_next valid=%b onehot=%h in_ready=%b required 1/01/1",
                     bus.out_valid, bus.out_onehot, bus.in_ready);
        end else begin
            $display("simultaneous: push 7 with pop, head=%h", bus.out_onehot);
        end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL simul_count valid=%b required 0 (occupancy should have stayed 1)", bus.out_valid);
        end
`ifdef DECO_STATS_EN
        n_checks++;
        if (dec_count !== 16'd12) begin
            n_errors++;
            $display("FAIL simul_stats dec_count=%0d required 12", dec_count);
        end
`endif
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_en = 1'b1; bus.in_code = 3'd1;
        @(negedge clk);
        bus.in_code = 3'd0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_onehot !== 8'h40) begin
            n_errors++;
            $display("FAIL mid_full in_ready=%b onehot=%h required 0/40", bus.in_ready, bus.out_onehot);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_onehot !== 8'h00 || bus.in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset valid=%b onehot=%h in_ready=%b required 0/00/0",
                     bus.out_valid, bus.out_onehot, bus.in_ready);
        end
`ifdef DECO_STATS_EN
        n_checks++;
        if (dec_count !== 16'd0) begin
            n_errors++;
            $display("FAIL mid_count dec_count=%0d required 0", dec_count);
        end
`endif
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_release valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
        end
        bus.in_valid = 1'b1; bus.in_code = 3'd3;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_onehot !== 8'h10) begin
            n_errors++;
            $display("FAIL mid_after valid=%b onehot=%h required 1/10", bus.out_valid, bus.out_onehot);
        end else begin
            $display("reset mid-stream: buffer cleared, next beat %h", bus.out_onehot);
        end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_drain valid=%b required 0 (stale beat survived reset)", bus.out_valid);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_code = '0; bus.in_en = 1'b0; bus.out_ready = 1'b0;
        test_reset();
        test_sweep();
        test_disable();
        test_backpressure();
        test_simultaneous();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/deco_pipe.md
# deco_pipe

Registered 3-to-8 line decoder with a valid/ready stream interface, the inverse of the team's 8-to-3 one-hot encoder. It accepts a 3-bit code plus enable per beat and produces the matching 8-bit one-hot word. The bit mapping is MSB-first: code 3'b000 maps to 8'b1000_0000, and code 3'b111 maps to 8'b0000_0001. A 2-entry buffer decouples producer from consumer so encode/decode paths can be chained without combinational ready loops.

## Interface
- CODE_W, 3, code width; LINE_W = 2**CODE_W, fixed at 8 for this block
- CNT_W, 16, width of statistics counter (only used with DECO_STATS_EN)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  producer has a beat
- in_code  in  3  code to decode
- in_en  in  1  beat enable; 0 means "no line selected"
- in_ready  out  1  block can accept a beat this cycle
- out_valid  out  1  out_onehot holds a valid beat
- out_onehot  out  8  decoded one-hot word
- out_ready  in  1  consumer takes the beat this cycle
- dec_count  out  CNT_W  count of enabled beats delivered (present only with DECO_STATS_EN)

## Operation
- Accept (push) when in_valid && in_ready; deliver (pop) when out_valid && out_ready.
- Decode at push: in_en=1 gives out word = 8'b1000_0000 >> in_code; in_en=0 gives 8'h00. No X values are ever stored or driven.
- Storage: 2 entries, occupancy `count` in {0,1,2}, in FIFO order. out_onehot always shows the oldest entry.
- in_ready = !rst && (count != 2). It depends only on registered state, never on out_ready.
- out_valid = (count != 0).
- Occupancy transitions:
  - push only: count+1
  - pop only: count-1
  - push and pop in the same cycle: count unchanged, the new entry queues behind the head
  - push at count 2 is impossible (in_ready low)
  - pop at count 0 is impossible (out_valid low)
- While out_valid && !out_ready, out_onehot stays stable (AXI-style hold).
- Reset mid-operation drops all buffered beats, with no partial output.

## Timing
- Reset values: out_valid 0, out_onehot 8'h00, count 0, dec_count 0; in_ready 0 while rst is high.
- Latency: a push in cycle N gives out_valid=1 with the decoded word in cycle N+1 if the buffer was empty.
- Throughput: 1 beat/cycle sustained when out_ready is held high.
- With out_ready low, two consecutive pushes fill the buffer; in_ready drops in the cycle after the second push.
- First cycle after rst deasserts: in_ready=1, out_valid=0.
- Output register contents after a pop to empty: don't-care for the consumer, but RTL drives 8'h00.

## Configuration
- DECO_STATS_EN defined:
  - dec_count port exists.
  - It increments by 1 on each pop whose word is nonzero (in_en=1 beats).
  - It saturates at 2**CNT_W-1 and clears only on rst.
- DECO_STATS_EN undefined: no dec_count port and no counter logic; datapath behaviour is identical.

## Structure
- Package deco_pkg:
  - CODE_W and LINE_W localparams
  - function code_to_onehot(code, en), returning the MSB-first one-hot word or 8'h00
- Sub-module deco_fifo2:
  - generic 2-entry valid/ready buffer, width LINE_W, with count, in_ready and out_valid logic
  - deco_pipe instantiates it and places code_to_onehot on its write data.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_onehot=8'h00; the cycle after release -> in_ready=1.
- Sweep: out_ready=1, push codes 0..7 with en=1 back-to-back -> out_onehot 80,40,20,10,08,04,02,01 on consecutive cycles, each one cycle after its push.
- Disable: push code 3'b101 with en=0 -> one beat with out_onehot=8'h00; with DECO_STATS_EN, dec_count unchanged.
- Backpressure: out_ready=0, push codes 2 and 6 -> in_ready=0 after the second; out_onehot holds 8'h20. Raise out_ready -> 8'h20 then 8'h02, and in_ready returns to 1.
- Simultaneous: at count=1, push code 7 while popping -> count stays 1 and the next beat is 8'h01.
- Reset mid-stream: with count=2, assert rst for one cycle -> out_valid=0, both beats lost, dec_count=0.
